// File: rtl/wb_sel_ctrl.sv
// -----------------------------------------------------------------------------
// wb_sel_ctrl
//
// Purpose:
//   Sequences one register-file write-back. It latches the requested source into
//   the 7:1 write-back mux selector and holds it there. It then waits for that
//   source to report ready data and issues a single-cycle write strobe. A request
//   ends early with an error pulse if the source code is illegal or the wait
//   runs past TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT   maximum cycles spent waiting for ready before err; 0 = no limit
//   CNT_W     wait counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous active-low reset
//   start      in   1  request pulse, only looked at while idle
//   src        in   3  requested source 0..6 (7 is illegal)
//   src_ready  in   7  per-source data-ready flags
//   flush      in   1  abandon a pending request while waiting
//   seletor    out  3  registered write-back mux select
//   reg_write  out  1  register-file write enable pulse
//   busy       out  1  request in progress (waiting or writing)
//   done       out  1  completion pulse, same cycle as reg_write
//   err        out  1  illegal-source or timeout pulse
// -----------------------------------------------------------------------------
module wb_sel_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] src,
    input  logic [6:0] src_ready,
    input  logic       flush,
    output logic [2:0] seletor,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Counter value in the last permitted wait cycle, and its saturation value.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ready;
    logic             w_timeout;
    logic             w_accept;

    // r_sel can never hold 7, so this index always lands inside src_ready.
    assign w_ready   = src_ready[r_sel];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LP_LAST);
    assign w_accept  = (r_state == S_IDLE) && start && (src != 3'd7);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. In WAIT, flush beats ready, and ready beats timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (src == 3'd7) ? S_ERR : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_ready) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WRITE: w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The selector loads only when a legal request is accepted, so it stays
    // frozen through WAIT and WRITE. The counter stops at all-ones instead of
    // wrapping; this only matters when the timeout is disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel <= 3'd0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sel <= src;
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !flush && !w_ready && !w_timeout &&
                     (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Output decode (Moore)
    always_comb begin
        seletor   = r_sel;
        reg_write = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/wb_sel_ctrl.md
Name: wb_sel_ctrl

Overview:
Multicycle sequencer that drives the 3-bit selector of the register-file write-back 7:1 mux (sources 0..6) and issues the register-file write strobe.
- Accepts a write-back request naming a source and holds the selector stable.
- Waits until that source reports its data is ready (memory wait states, mult/div done), then pulses reg_write for exactly one cycle.
- Sits between the main control FSM and the write-back mux/register bank.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before aborting with err; 0 disables the timeout.
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request pulse from control FSM, sampled only in IDLE
src  input  3  requested write-back source code 0..6; 7 is illegal
src_ready  input  7  per-source data-ready flags, bit i = source i ready
flush  input  1  synchronous abort of a pending request
seletor  output  3  registered select for the write-back mux
reg_write  output  1  register-file write enable, one-cycle pulse
busy  output  1  high in WAIT and WRITE
done  output  1  one-cycle pulse, coincident with reg_write
err  output  1  one-cycle pulse on illegal src or timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, seletor=3'b000, reg_write=0, busy=0, done=0, err=0, counter=0. Takes effect immediately, including mid-request; no write is issued after reset.
- Outputs reg_write/busy/done/err are Moore-decoded from registered state; seletor is a register.
- States: IDLE, WAIT, WRITE, ERR.
- IDLE:
  - start=1 and src<=6: seletor<=src, counter<=0, go to WAIT.
  - start=1 and src==7: go to ERR; seletor unchanged.
  - start=0: stay in IDLE; seletor holds its last value.
- WAIT (busy=1):
  - Priority: flush > ready > timeout.
  - flush=1: go to IDLE, no reg_write, no err.
  - src_ready[seletor]=1: go to WRITE.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: go to ERR. Else counter<=counter+1 and stay in WAIT.
  - Only the ready bit of the selected source matters; other bits are ignored.
- WRITE (busy=1, reg_write=1, done=1): unconditionally go to IDLE next cycle; flush is ignored in this state.
- ERR (err=1, busy=0): unconditionally go to IDLE next cycle.
- start is ignored outside IDLE: no queuing, no effect on seletor.
- seletor never changes in WAIT or WRITE, so the mux output is stable through the write.
- Latency, with start sampled at edge k:
  - WAIT during cycle k+1.
  - If ready is high at edge k+1: WRITE during cycle k+2, IDLE at k+3.
  - Minimum start-to-reg_write is 2 cycles; each extra not-ready cycle adds 1.
  - Timeout err is high in cycle k+1+TIMEOUT when ready never rises.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after WRITE or ERR, giving a minimum 3-cycle request period.
- Counter saturation: the counter never wraps. It is cleared on entry to WAIT; with TIMEOUT=0 it saturates at its maximum value.

Test Plan:
- Reset, then start=1, src=4, src_ready=7'b0010000 -> seletor=4 from cycle k+1; reg_write=done=1 in cycle k+2 only; busy high in k+1..k+2.
- start, src=1, src_ready[1] low for 5 cycles then high -> WAIT held 6 cycles, seletor=1 throughout, single reg_write pulse.
- TIMEOUT=16, start with src=3, src_ready=0 forever -> err=1 in cycle k+17, reg_write never asserted, returns to IDLE.
- start with src=7 -> err pulse next cycle, seletor keeps its previous value (e.g. 4), busy stays 0.
- In WAIT, flush=1 together with src_ready[sel]=1 -> IDLE next cycle, no reg_write. Separately, a start pulse during WAIT is ignored.
- Assert reset=0 asynchronously in WAIT, between clock edges -> all outputs 0 and seletor=0 immediately; after release, no stray reg_write.
